bot_result_collector: RTL and testbench

- Sits on the output side of pipeline24Pack and consumes its per-bot results.
- The feeder asserts botIssued in the same cycle as isBotValid. The collector tracks each bot through the fixed pipeline lag with a valid delay line, then samples summedData/pcoeffCount exactly OUTPUT_LAG cycles later.
- Accumulates one job (one top, N bots) into a wide sum and count, and hands the total to the host over a valid/ready handshake.
- Gates further issue for the job through issueAllowed.

---
 rtl/bot_result_collector.sv | 118 +++++++++++
 tb/tb_bot_result_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_result_collector.sv
// Per-job collector for pipeline24Pack results: tracks bots through the
// fixed pipeline lag, accumulates sum/count and hands totals to the host.
module bot_result_collector #(
  parameter int OUTPUT_LAG  = 36,
  parameter int SUM_WIDTH   = 64,
  parameter int COUNT_WIDTH = 32,
  parameter int BOTS_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jobStart,
  input  logic [BOTS_WIDTH-1:0]  jobBotCount,
  input  logic                   botIssued,
  input  logic [39:0]            summedData,
  input  logic [4:0]             pcoeffCount,
  output logic                   issueAllowed,
  output logic                   resultValid,
  input  logic                   resultReady,
  output logic [SUM_WIDTH-1:0]   resultSum,
  output logic [COUNT_WIDTH-1:0] resultCount,
  output logic                   busy,
  output logic                   protocolErr
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, HOLD
  } state_t;

  state_t state, stateNext;

  logic [OUTPUT_LAG-1:0]  dly;
  logic [BOTS_WIDTH-1:0]  nBots;
  logic [BOTS_WIDTH-1:0]  issued;
  logic [BOTS_WIDTH-1:0]  retired;
  logic [BOTS_WIDTH-1:0]  issuedNext;
  logic [BOTS_WIDTH-1:0]  retiredNext;
  logic [SUM_WIDTH-1:0]   sumAcc;
  logic [COUNT_WIDTH-1:0] cntAcc;
  logic retireValid;
  logic accept;
  logic active;
  logic retireOk;
  logic errNow;

  assign active       = (state == RUN) || (state == DRAIN);
  assign issueAllowed = (state == RUN) && (issued < nBots);
  assign accept       = botIssued & issueAllowed;
  assign retireValid  = dly[OUTPUT_LAG-1];
  assign retireOk     = retireValid & active;
  assign issuedNext   = issued + BOTS_WIDTH'(accept);
  assign retiredNext  = retired + BOTS_WIDTH'(retireOk);

  // Retires outside an active job can only come from a broken feeder.
  assign errNow = (botIssued & ~issueAllowed)
                | (retireValid & ~active);

  assign resultValid = (state == HOLD);
  assign busy        = (state != IDLE);
  assign resultSum   = sumAcc;
  assign resultCount = cntAcc;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (jobStart) begin
          stateNext = (jobBotCount == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (issuedNext == nBots) stateNext = DRAIN;
      end
      DRAIN: begin
        if (retiredNext == nBots) stateNext = HOLD;
      end
      HOLD: begin
        if (resultReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly         <= '0;
      nBots       <= '0;
      issued      <= '0;
      retired     <= '0;
      sumAcc      <= '0;
      cntAcc      <= '0;
      protocolErr <= 1'b0;
    end else begin
      dly         <= (dly << 1) | OUTPUT_LAG'(accept);
      protocolErr <= protocolErr | errNow;
      if (state == IDLE && jobStart) begin
        nBots   <= jobBotCount;
        issued  <= '0;
        retired <= '0;
      end else begin
        issued  <= issuedNext;
        retired <= retiredNext;
      end
      if (state == HOLD && resultReady) begin
        sumAcc <= '0;
        cntAcc <= '0;
      end else if (retireOk) begin
        sumAcc <= sumAcc + SUM_WIDTH'(summedData);
        cntAcc <= cntAcc + COUNT_WIDTH'(pcoeffCount);
      end
    end
  end

endmodule

// File: tb/tb_bot_result_collector.sv
// Directed bench for bot_result_collector with a pipeline model
// and a scoreboard of expected job totals.
module tb_bot_result_collector;

  localparam int LAG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jobStart = 1'b0;
  logic [15:0] jobBotCount = '0;
  logic        botIssued = 1'b0;
  logic [39:0] summedData;
  logic [4:0]  pcoeffCount;
  logic        issueAllowed;
  logic        resultValid;
  logic        resultReady = 1'b0;
  logic [63:0] resultSum;
  logic [31:0] resultCount;
  logic        busy;
  logic        protocolErr;

  logic [39:0] inSum = '0;
  logic [4:0]  inCnt = '0;
  logic [39:0] ps [LAG];
  logic [4:0]  pc [LAG];

  typedef struct {
    logic [63:0] s;
    logic [31:0] c;
  } res_t;
  res_t sbq [$];

  int tests = 0;
  int fails = 0;

  bot_result_collector #(
    .OUTPUT_LAG(LAG),
    .SUM_WIDTH(64),
    .COUNT_WIDTH(32),
    .BOTS_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jobStart(jobStart),
    .jobBotCount(jobBotCount),
    .botIssued(botIssued),
    .summedData(summedData),
    .pcoeffCount(pcoeffCount),
    .issueAllowed(issueAllowed),
    .resultValid(resultValid),
    .resultReady(resultReady),
    .resultSum(resultSum),
    .resultCount(resultCount),
    .busy(busy),
    .protocolErr(protocolErr)
  );

  always #5 clk = ~clk;

  // Fixed-lag pipeline: values fed at an edge appear LAG edges later.
  always @(posedge clk) begin
    ps[0] <= inSum;
    pc[0] <= inCnt;
    for (int i = 1; i < LAG; i++) begin
      ps[i] <= ps[i-1];
      pc[i] <= pc[i-1];
    end
  end
  assign summedData  = ps[LAG-1];
  assign pcoeffCount = pc[LAG-1];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: table (10,1)(20,2)(5,3); 1: all-ones; 2: random; 3: (7,1)
  task automatic issueBots(input int n, input int mode,
                           output logic [63:0] s,
                           output logic [31:0] c);
    logic [63:0] r;
    s = '0;
    c = '0;
    for (int i = 0; i < n; i++) begin
      botIssued = 1'b1;
      case (mode)
        0: begin
          inSum = (i == 0) ? 40'd10 : (i == 1) ? 40'd20 : 40'd5;
          inCnt = 5'(i + 1);
        end
        1: begin
          inSum = '1;
          inCnt = 5'd31;
        end
        3: begin
          inSum = 40'd7;
          inCnt = 5'd1;
        end
        default: begin
          r = {$urandom, $urandom};
          inSum = r[39:0];
          inCnt = 5'($urandom_range(0, 31));
        end
      endcase
      s = s + 64'(inSum);
      c = c + 32'(inCnt);
      step();
    end
    botIssued = 1'b0;
  endtask

  task automatic waitResult(input string tag, output int k);
    res_t e;
    k = 0;
    while (resultValid !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    chk({tag, ".valid"}, 64'(resultValid), 64'd1);
    chk({tag, ".sbq"}, 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".sum"}, resultSum, e.s);
      chk({tag, ".cnt"}, 64'(resultCount), 64'(e.c));
    end
  endtask

  task automatic ack(input string tag);
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    chk({tag, ".idleBusy"}, 64'(busy), 64'd0);
    chk({tag, ".idleValid"}, 64'(resultValid), 64'd0);
    chk({tag, ".idleSum"}, resultSum, 64'd0);
  endtask

  task automatic startJob(input int n);
    jobBotCount = 16'(n);
    jobStart = 1'b1;
    step();
    jobStart = 1'b0;
  endtask

  initial begin
    logic [63:0] s;
    logic [31:0] c;
    logic [63:0] s2;
    logic [31:0] c2;
    int k;

    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(resultValid), 64'd0);
    chk("rst.allow", 64'(issueAllowed), 64'd0);
    chk("rst.err", 64'(protocolErr), 64'd0);
    chk("rst.sum", resultSum, 64'd0);
    rst = 1'b1;
    step();

    // Basic three-bot job and its latency
    startJob(3);
    chk("t1.allowRun", 64'(issueAllowed), 64'd1);
    issueBots(3, 0, s, c);
    sbq.push_back('{s: s, c: c});
    chk("t1.allowDrain", 64'(issueAllowed), 64'd0);
    waitResult("t1", k);
    chk("t1.latency", 64'(k), 64'(LAG));
    chk("t1.sum35", resultSum, 64'd35);
    ack("t1");

    // Empty job holds 0/0 until accepted
    startJob(0);
    chk("t2.validNext", 64'(resultValid), 64'd1);
    sbq.push_back('{s: 64'd0, c: 32'd0});
    waitResult("t2", k);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2.holdValid", 64'(resultValid), 64'd1);
      chk("t2.holdSum", resultSum, 64'd0);
    end
    ack("t2");

    // Long job: issue and retire overlap, max-value results
    startJob(100);
    issueBots(100, 1, s, c);
    sbq.push_back('{s: 64'd100 * ((64'd1 << 40) - 64'd1),
                    c: 32'd3100});
    waitResult("t3", k);
    chk("t3.errClean", 64'(protocolErr), 64'd0);
    ack("t3");

    // jobStart during RUN is ignored
    startJob(3);
    issueBots(1, 2, s, c);
    jobStart = 1'b1;
    jobBotCount = 16'd7;
    issueBots(1, 2, s2, c2);
    jobStart = 1'b0;
    s = s + s2;
    c = c + c2;
    issueBots(1, 2, s2, c2);
    s = s + s2;
    c = c + c2;
    sbq.push_back('{s: s, c: c});
    chk("t6.allowDone", 64'(issueAllowed), 64'd0);
    chk("t6.busy", 64'(busy), 64'd1);
    waitResult("t6", k);
    ack("t6");

    // Illegal issue during DRAIN sets sticky error only
    startJob(2);
    issueBots(2, 2, s, c);
    sbq.push_back('{s: s, c: c});
    botIssued = 1'b1;
    inSum = 40'hFF_FFFF;
    inCnt = 5'd9;
    step();
    botIssued = 1'b0;
    chk("t4.err", 64'(protocolErr), 64'd1);
    waitResult("t4", k);
    ack("t4");
    chk("t4.errSticky", 64'(protocolErr), 64'd1);

    // Reset mid-DRAIN discards in-flight bots
    startJob(3);
    issueBots(3, 2, s, c);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("t5.busy", 64'(busy), 64'd0);
    chk("t5.sum", resultSum, 64'd0);
    chk("t5.cnt", 64'(resultCount), 64'd0);
    chk("t5.err", 64'(protocolErr), 64'd0);
    chk("t5.valid", 64'(resultValid), 64'd0);
    #2;
    rst = 1'b1;
    step();
    startJob(1);
    issueBots(1, 3, s, c);
    sbq.push_back('{s: 64'd7, c: 32'd1});
    waitResult("t5", k);
    chk("t5.errAfter", 64'(protocolErr), 64'd0);
    ack("t5");

    chk("sbq.empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
